// File: rtl/preproc_capture_sched.sv
// Capture scheduler: picks the sample source, decimates, removes DC offset with
// saturation and frames samples into AXI-Stream packets separated by idle gaps.
module preproc_capture_sched #(
  parameter int ADC_WIDTH         = 14,
  parameter int OUT_WIDTH         = 16,
  parameter int CLOCKS_PER_SAMPLE = 3,
  parameter int LEN_WIDTH         = 16,
  parameter int CNT_WIDTH         = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [1:0]           cfg_src_sel_i,
  input  logic [ADC_WIDTH-1:0] cfg_offset_i,
  input  logic [LEN_WIDTH-1:0] cfg_pkt_len_i,
  input  logic [CNT_WIDTH-1:0] cfg_pkt_num_i,
  input  logic [7:0]           cfg_gap_i,
  input  logic [ADC_WIDTH-1:0] adc_data_i,
  input  logic [ADC_WIDTH-1:0] tone_data_i,
  output logic [OUT_WIDTH-1:0] m_tdata_o,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic                 m_tlast_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o
);

  // state   | meaning
  // IDLE    | waiting for start
  // CAPTURE | strobing samples into the output register
  // GAP     | idle clocks between packets
  // FLUSH   | draining the last pending beat
  // DONE    | one-clock done pulse, then back to IDLE
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_GAP     = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int DIV_W = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLOCKS_PER_SAMPLE - 1);
  localparam logic signed [ADC_WIDTH-1:0] SAT_MAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic signed [ADC_WIDTH-1:0] SAT_MIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};

  state_t                       state_q, state_d;
  logic [1:0]                   src_q, src_d;
  logic signed [ADC_WIDTH-1:0]  offset_q, offset_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d;
  logic [CNT_WIDTH-1:0]         num_q, num_d;
  logic [7:0]                   gap_q, gap_d;
  logic [DIV_W-1:0]             div_q, div_d;
  logic [LEN_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]         pkt_cnt_q, pkt_cnt_d;
  logic [7:0]                   gap_cnt_q, gap_cnt_d;
  logic                         abort_q, abort_d;
  logic                         ovf_q, ovf_d;
  logic                         tvalid_q, tvalid_d;
  logic                         tlast_q, tlast_d;
  logic [OUT_WIDTH-1:0]         tdata_q, tdata_d;
  logic                         done_q, done_d;
  logic                         busy_q, busy_d;

  logic signed [ADC_WIDTH-1:0]  src_s, sat_s;
  logic signed [ADC_WIDTH:0]    diff_s;
  logic signed [OUT_WIDTH-1:0]  ext_s;

  always_comb begin
    case (src_q)
      2'd1:    src_s = $signed(tone_data_i);
      2'd2:    src_s = '0;
      default: src_s = $signed(adc_data_i);
    endcase
    diff_s = $signed({src_s[ADC_WIDTH-1], src_s}) - $signed({offset_q[ADC_WIDTH-1], offset_q});
    if (diff_s[ADC_WIDTH] != diff_s[ADC_WIDTH-1]) begin
      sat_s = diff_s[ADC_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_s = diff_s[ADC_WIDTH-1:0];
    end
    ext_s = OUT_WIDTH'(sat_s);
  end

  logic strobe, accept, last_accept, more_pkts, leaving, load, drop;

  always_comb begin
    strobe      = (state_q == S_CAPTURE) && (div_q == DIV_MAX);
    accept      = tvalid_q && m_tready_i;
    last_accept = accept && tlast_q;
    more_pkts   = (num_q == '0) || (pkt_cnt_q != num_q);
    // A strobe on the edge that closes a packet before a gap or flush belongs to no packet.
    leaving     = last_accept && (!more_pkts || (gap_q != 8'd0));
    load        = strobe && (!tvalid_q || m_tready_i) && !abort_i && !leaving;
    drop        = strobe && tvalid_q && !m_tready_i && !abort_i;
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    offset_d  = offset_q;
    len_d     = len_q;
    num_d     = num_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    gap_cnt_d = gap_cnt_q;
    abort_d   = abort_q;
    ovf_d     = ovf_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    div_d     = '0;

    if (state_q == S_CAPTURE) begin
      div_d = strobe ? '0 : div_q + DIV_W'(1);
    end

    if (load) begin
      tdata_d  = ext_s;
      tvalid_d = 1'b1;
      tlast_d  = (cnt_q == len_q - LEN_WIDTH'(1));
      if (cnt_q == len_q - LEN_WIDTH'(1)) begin
        cnt_d     = '0;
        pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
      end else begin
        cnt_d = cnt_q + LEN_WIDTH'(1);
      end
    end else if (accept) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d     = cfg_src_sel_i;
          offset_d  = $signed(cfg_offset_i);
          len_d     = (cfg_pkt_len_i == '0) ? LEN_WIDTH'(1) : cfg_pkt_len_i;
          num_d     = cfg_pkt_num_i;
          gap_d     = cfg_gap_i;
          cnt_d     = '0;
          pkt_cnt_d = '0;
          ovf_d     = 1'b0;
          abort_d   = 1'b0;
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (abort_i) begin
          abort_d = 1'b1;
          state_d = S_FLUSH;
        end else if (last_accept) begin
          if (!more_pkts) begin
            state_d = S_FLUSH;
          end else if (gap_q != 8'd0) begin
            gap_cnt_d = gap_q - 8'd1;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (abort_i) begin
          abort_d = 1'b1;
          state_d = S_FLUSH;
        end else if (gap_cnt_q == 8'd0) begin
          state_d = S_CAPTURE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      S_FLUSH: begin
        if (!tvalid_q || accept) begin
          state_d = abort_q ? S_IDLE : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      offset_q  <= '0;
      len_q     <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      pkt_cnt_q <= '0;
      gap_cnt_q <= '0;
      abort_q   <= 1'b0;
      ovf_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      offset_q  <= offset_d;
      len_q     <= len_d;
      num_q     <= num_d;
      gap_q     <= gap_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      abort_q   <= abort_d;
      ovf_q     <= ovf_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign m_tdata_o  = tdata_q;
  assign m_tvalid_o = tvalid_q;
  assign m_tlast_o  = tlast_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_preproc_capture_sched.sv
// Directed bench for preproc_capture_sched: hand-computed beat timing, data,
// framing, backpressure, abort, reset and start-ignore behaviour.
module tb_preproc_capture_sched;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [1:0]  cfg_src_sel_i = '0;
  logic [13:0] cfg_offset_i = '0;
  logic [15:0] cfg_pkt_len_i = '0;
  logic [7:0]  cfg_pkt_num_i = '0;
  logic [7:0]  cfg_gap_i = '0;
  logic [13:0] adc_data_i;
  logic [13:0] tone_data_i = '0;
  logic        m_tready_i = 1'b1;
  logic [15:0] m_tdata_o;
  logic        m_tvalid_o, m_tlast_o, busy_o, done_o, overflow_o;
  logic [7:0]  pkt_cnt_o;

  preproc_capture_sched dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
    .cfg_src_sel_i(cfg_src_sel_i), .cfg_offset_i(cfg_offset_i),
    .cfg_pkt_len_i(cfg_pkt_len_i), .cfg_pkt_num_i(cfg_pkt_num_i), .cfg_gap_i(cfg_gap_i),
    .adc_data_i(adc_data_i), .tone_data_i(tone_data_i),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .m_tlast_o(m_tlast_o), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int start_edge = 0;
  int beat_base = 0;
  int done_base = 0;
  int nbeats = 0;
  int done_cnt = 0;
  int done_rel = 0;
  logic ramp_en = 1'b0;
  logic [15:0] beat_data [128];
  logic        beat_last [128];
  int          beat_cyc  [128];
  logic [7:0]  beat_pkt  [128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  // ADC ramp: value during the clock after edge k of a run is 100+k.
  always @(posedge clk) begin
    #2;
    adc_data_i = ramp_en ? 14'(100 + edge_cnt - start_edge) : 14'd0;
  end

  always @(negedge clk) begin
    if (m_tvalid_o && m_tready_i && nbeats < 128) begin
      beat_data[nbeats] = m_tdata_o;
      beat_last[nbeats] = m_tlast_o;
      beat_cyc[nbeats]  = edge_cnt - start_edge + 1;
      beat_pkt[nbeats]  = pkt_cnt_o;
      nbeats++;
    end
    if (done_o) begin
      done_cnt++;
      done_rel = edge_cnt - start_edge + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] src, input logic [13:0] off, input logic [15:0] len,
                          input logic [7:0] num, input logic [7:0] gap, input logic with_abort);
    cfg_src_sel_i = src;
    cfg_offset_i  = off;
    cfg_pkt_len_i = len;
    cfg_pkt_num_i = num;
    cfg_gap_i     = gap;
    start_i       = 1'b1;
    abort_i       = with_abort;
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    start_edge = edge_cnt;
    beat_base  = nbeats;
    done_base  = done_cnt;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && busy_o; i++) step();
    check(tag, 32'(busy_o), 32'd0);
  endtask

  function automatic int nb();
    return nbeats - beat_base;
  endfunction

  logic [13:0] sat_tone [3];
  logic [13:0] sat_off  [3];
  logic [1:0]  sat_src  [3];
  logic [15:0] sat_exp  [3];
  int          mp_cyc   [6];
  logic [15:0] held;

  initial begin
    sat_tone[0] = -14'sd8000; sat_off[0] = 14'sd500;  sat_src[0] = 2'd1; sat_exp[0] = 16'hE000;
    sat_tone[1] = 14'sd8000;  sat_off[1] = -14'sd500; sat_src[1] = 2'd1; sat_exp[1] = 16'h1FFF;
    sat_tone[2] = 14'sd0;     sat_off[2] = 14'sd5;    sat_src[2] = 2'd2; sat_exp[2] = 16'hFFFB;
    mp_cyc[0] = 4;  mp_cyc[1] = 7;  mp_cyc[2] = 16;
    mp_cyc[3] = 19; mp_cyc[4] = 28; mp_cyc[5] = 31;

    // Reset state
    repeat (3) step();
    check("rst_tvalid", 32'(m_tvalid_o), 32'd0);
    check("rst_tlast", 32'(m_tlast_o), 32'd0);
    check("rst_tdata", 32'(m_tdata_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_pkt", 32'(pkt_cnt_o), 32'd0);
    rst_n_i = 1'b1;
    step();

    // Single packet from the ADC ramp: beats on clocks 4,7,10,13 carrying 99+3n
    ramp_en = 1'b1;
    do_start(2'd0, 14'd0, 16'd4, 8'd1, 8'd0, 1'b0);
    wait_idle("sp_idle", 40);
    check("sp_nbeats", 32'(nb()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sp_cyc%0d", i), 32'(beat_cyc[beat_base+i]), 32'(4 + 3*i));
      check($sformatf("sp_data%0d", i), 32'(beat_data[beat_base+i]), 32'(102 + 3*i));
      check($sformatf("sp_last%0d", i), 32'(beat_last[beat_base+i]), 32'(i == 3));
    end
    check("sp_done_cnt", 32'(done_cnt - done_base), 32'd1);
    check("sp_done_clk", 32'(done_rel), 32'd15);
    check("sp_pkt", 32'(pkt_cnt_o), 32'd1);
    ramp_en = 1'b0;

    // Saturation and zero source
    for (int k = 0; k < 3; k++) begin
      tone_data_i = sat_tone[k];
      do_start(sat_src[k], sat_off[k], 16'd1, 8'd1, 8'd0, 1'b0);
      wait_idle($sformatf("sat%0d_idle", k), 30);
      check($sformatf("sat%0d_nbeats", k), 32'(nb()), 32'd1);
      check($sformatf("sat%0d_data", k), 32'(beat_data[beat_base]), 32'(sat_exp[k]));
      check($sformatf("sat%0d_last", k), 32'(beat_last[beat_base]), 32'd1);
    end

    // Three packets of two with a 5-clock gap; zero source minus offset -3 gives 3
    do_start(2'd2, -14'sd3, 16'd2, 8'd3, 8'd5, 1'b0);
    wait_idle("mp_idle", 80);
    check("mp_nbeats", 32'(nb()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("mp_cyc%0d", i), 32'(beat_cyc[beat_base+i]), 32'(mp_cyc[i]));
      check($sformatf("mp_last%0d", i), 32'(beat_last[beat_base+i]), 32'(i % 2 == 1));
      check($sformatf("mp_data%0d", i), 32'(beat_data[beat_base+i]), 32'd3);
    end
    check("mp_pkt1", 32'(beat_pkt[beat_base+1]), 32'd1);
    check("mp_pkt2", 32'(beat_pkt[beat_base+3]), 32'd2);
    check("mp_pkt3", 32'(beat_pkt[beat_base+5]), 32'd3);
    check("mp_done_cnt", 32'(done_cnt - done_base), 32'd1);

    // Backpressure: ready low for 10 clocks, first beat held, later strobes dropped
    ramp_en = 1'b1;
    m_tready_i = 1'b0;
    do_start(2'd0, 14'd0, 16'd8, 8'd1, 8'd0, 1'b0);
    repeat (5) step();
    held = m_tdata_o;
    check("bp_valid_held", 32'(m_tvalid_o), 32'd1);
    repeat (5) step();
    check("bp_data_stable", 32'(m_tdata_o), 32'(held));
    check("bp_data_val", 32'(m_tdata_o), 32'd102);
    check("bp_ovf", 32'(overflow_o), 32'd1);
    m_tready_i = 1'b1;
    wait_idle("bp_idle", 60);
    check("bp_nbeats", 32'(nb()), 32'd8);
    check("bp_last8", 32'(beat_last[beat_base+7]), 32'd1);
    check("bp_last7", 32'(beat_last[beat_base+6]), 32'd0);
    check("bp_data2", 32'(beat_data[beat_base+1]), 32'd111);
    check("bp_ovf_sticky", 32'(overflow_o), 32'd1);
    ramp_en = 1'b0;
    do_start(2'd2, 14'd0, 16'd1, 8'd1, 8'd0, 1'b0);
    check("bp_ovf_clear", 32'(overflow_o), 32'd0);
    wait_idle("bp2_idle", 30);

    // Continuous run aborted with a beat pending
    tone_data_i = 14'd7;
    do_start(2'd1, 14'd0, 16'd4, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 100 && nb() < 5; i++) step();
    check("ab_five", 32'(nb()), 32'd5);
    m_tready_i = 1'b0;
    for (int i = 0; i < 20 && !m_tvalid_o; i++) step();
    check("ab_pending", 32'(m_tvalid_o), 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    repeat (3) step();
    check("ab_valid_held", 32'(m_tvalid_o), 32'd1);
    check("ab_data_held", 32'(m_tdata_o), 32'd7);
    check("ab_busy", 32'(busy_o), 32'd1);
    check("ab_pkt", 32'(pkt_cnt_o), 32'd1);
    m_tready_i = 1'b1;
    wait_idle("ab_idle", 20);
    check("ab_nbeats", 32'(nb()), 32'd6);
    check("ab_no_tlast", 32'(beat_last[beat_base+5]), 32'd0);
    check("ab_no_done", 32'(done_cnt - done_base), 32'd0);

    // Reset mid-packet
    m_tready_i = 1'b0;
    do_start(2'd1, 14'd0, 16'd1, 8'd0, 8'd0, 1'b0);
    repeat (8) step();
    check("mr_pre_valid", 32'(m_tvalid_o), 32'd1);
    check("mr_pre_ovf", 32'(overflow_o), 32'd1);
    check("mr_pre_pkt", 32'(pkt_cnt_o), 32'd1);
    rst_n_i = 1'b0;
    step();
    check("mr_tvalid", 32'(m_tvalid_o), 32'd0);
    check("mr_tlast", 32'(m_tlast_o), 32'd0);
    check("mr_tdata", 32'(m_tdata_o), 32'd0);
    check("mr_busy", 32'(busy_o), 32'd0);
    check("mr_done", 32'(done_o), 32'd0);
    check("mr_ovf", 32'(overflow_o), 32'd0);
    check("mr_pkt", 32'(pkt_cnt_o), 32'd0);
    rst_n_i = 1'b1;
    m_tready_i = 1'b1;
    step();

    // Start while busy is ignored
    tone_data_i = 14'd10;
    do_start(2'd1, 14'd0, 16'd2, 8'd2, 8'd0, 1'b0);
    repeat (5) step();
    cfg_src_sel_i = 2'd2;
    cfg_offset_i  = 14'd3;
    cfg_pkt_len_i = 16'd5;
    cfg_pkt_num_i = 8'd1;
    cfg_gap_i     = 8'd9;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_idle("si_idle", 60);
    check("si_nbeats", 32'(nb()), 32'd4);
    check("si_data0", 32'(beat_data[beat_base]), 32'd10);
    check("si_data3", 32'(beat_data[beat_base+3]), 32'd10);
    check("si_last0", 32'(beat_last[beat_base]), 32'd0);
    check("si_last1", 32'(beat_last[beat_base+1]), 32'd1);
    check("si_last3", 32'(beat_last[beat_base+3]), 32'd1);
    check("si_cyc3", 32'(beat_cyc[beat_base+3]), 32'd13);
    check("si_done_cnt", 32'(done_cnt - done_base), 32'd1);
    check("si_pkt", 32'(pkt_cnt_o), 32'd2);

    // Start and abort together in IDLE: start wins
    do_start(2'd2, 14'd3, 16'd5, 8'd1, 8'd9, 1'b1);
    check("sa_busy", 32'(busy_o), 32'd1);
    wait_idle("sa_idle", 60);
    check("sa_nbeats", 32'(nb()), 32'd5);
    check("sa_data", 32'(beat_data[beat_base]), 32'h0000FFFD);
    check("sa_last", 32'(beat_last[beat_base+4]), 32'd1);
    check("sa_done_cnt", 32'(done_cnt - done_base), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/preproc_capture_sched.md
Name: preproc_capture_sched

Overview:
Capture scheduler for the preprocessing stage. Picks the sample source (ADC, test tone, or zero) and decimates the input stream to one sample every CLOCKS_PER_SAMPLE clocks. Removes the DC offset with saturation, frames the results into AXI-Stream packets of programmable length and count, and inserts an idle gap between packets. Sits between the ADC/tone front end and the downstream preprocessing datapath. Its configuration comes from the register block.

Parameters:
ADC_WIDTH, 14, sample width (signed two's complement).
OUT_WIDTH, 16, m_tdata width; samples are sign-extended to this width.
CLOCKS_PER_SAMPLE, 3, clocks per sample strobe (>=1).
LEN_WIDTH, 16, width of cfg_pkt_len.
CNT_WIDTH, 8, width of cfg_pkt_num and pkt_cnt.

Ports:
clk  in  1  ADC clock; all logic on the rising edge.
rst_n  in  1  synchronous reset, active-low.
start  in  1  one-cycle pulse; starts a capture run. Honoured only in IDLE.
abort  in  1  one-cycle pulse; stops a run in progress.
cfg_src_sel  in  2  source select: 0 = ADC, 1 = tone, 2 = zero, 3 = ADC.
cfg_offset  in  ADC_WIDTH  signed offset, subtracted from every sample.
cfg_pkt_len  in  LEN_WIDTH  samples per packet; 0 is treated as 1.
cfg_pkt_num  in  CNT_WIDTH  packets per run; 0 means continuous until abort.
cfg_gap  in  8  idle clocks between packets.
adc_data  in  ADC_WIDTH  signed ADC sample.
tone_data  in  ADC_WIDTH  signed test-tone sample.
m_tdata  out  OUT_WIDTH  output sample.
m_tvalid  out  1  AXI-Stream valid.
m_tready  in  1  AXI-Stream ready.
m_tlast  out  1  last sample of the packet.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse when a run of cfg_pkt_num packets completes.
overflow  out  1  sticky flag: a sample was dropped. Cleared on start or reset.
pkt_cnt  out  CNT_WIDTH  packets completed in the current run.

Behaviour:
- Reset (rst_n low at an edge): state = IDLE. m_tvalid, m_tlast, m_tdata, busy, done, overflow, pkt_cnt and all internal counters are set to 0. Reset is honoured in any state, including mid-packet; a pending beat is discarded.
- Config latch: on start in IDLE, all cfg_* inputs are latched. pkt_cnt, the sample counter and overflow are cleared. Config changes during a run have no effect.
- State machine: IDLE, CAPTURE, GAP, FLUSH, DONE.
  - IDLE -> CAPTURE on start.
  - CAPTURE -> GAP when the last sample of a packet is accepted and more packets remain, with gap > 0. With gap = 0, stay in CAPTURE.
  - CAPTURE -> FLUSH when the last sample of the final packet is accepted (pkt_num != 0).
  - GAP -> CAPTURE after exactly gap clocks in GAP.
  - FLUSH -> DONE when m_tvalid = 0, or when m_tvalid & m_tready.
  - DONE -> IDLE after 1 clock; done = 1 during that clock.
  - abort in CAPTURE or GAP -> FLUSH with an abort flag set. No done pulse follows; the state returns to IDLE directly from FLUSH.
  - start while busy is ignored. If start and abort arrive in the same cycle in IDLE, start wins.
- Strobe divider:
  - The divider is cleared on every entry to CAPTURE.
  - strobe = 1 when divider = CLOCKS_PER_SAMPLE-1; the divider then wraps to 0.
  - The first sample is taken on the CLOCKS_PER_SAMPLE-th clock in CAPTURE.
- Sample path:
  - On strobe, select the source, then compute diff = sext(src) - sext(cfg_offset) at ADC_WIDTH+1 bits.
  - Saturate diff to [-2^(ADC_WIDTH-1), 2^(ADC_WIDTH-1)-1].
  - Sign-extend the result to OUT_WIDTH and load it into the output register.
  - m_tvalid rises on the clock after the strobe (latency 1).
- Output register: one entry, AXI-compliant.
  - m_tdata and m_tlast are held stable while m_tvalid & !m_tready.
  - If the register is still full at a strobe, the new sample is dropped and overflow is set. A dropped sample does not advance the sample counter, so packet length stays exact.
  - If a strobe coincides with m_tready (register draining), the new sample is loaded with no drop.
- Counters:
  - The sample counter increments on each loaded sample.
  - m_tlast = 1 on the sample where count = len-1; the counter then wraps to 0 and pkt_cnt increments.
  - With pkt_num = 0, pkt_cnt wraps modulo 2^CNT_WIDTH.
- Abort mid-packet: a pending beat stays valid until accepted; no tlast is forced, so the packet is truncated.

Test Plan:
- Single packet, CLOCKS_PER_SAMPLE = 3. Drive src = ADC, offset = 0, len = 4, num = 1, gap = 0, m_tready = 1, adc_data = 100, 101, 102, ... changing every clock. Required: 4 beats, one every 3 clocks, the first on clock 4 after start. tlast on beat 4 only. done pulses exactly once; busy then falls; pkt_cnt = 1.
- Saturation, src = tone. Case A: tone = -8000, offset = 500 -> m_tdata = 0xE000 (-8192). Case B: tone = 8000, offset = -500 -> m_tdata = 0x1FFF (8191). Case C: src = zero, offset = 5 -> m_tdata = 0xFFFB.
- Multiple packets with gap: len = 2, num = 3, gap = 5. Required: 6 beats; tlast on beats 2, 4 and 6. Exactly 5 idle clocks in GAP between packets, then 3 clocks to the next sample; pkt_cnt counts 1, 2, 3.
- Backpressure: hold m_tready = 0 for 10 clocks with len = 8. Required:
  - overflow = 1 and m_tdata stays stable while held.
  - After release, the packet still carries exactly 8 beats and tlast on the 8th.
  - A new start clears overflow.
- Abort and reset: num = 0 (continuous); abort after 5 beats with a beat pending and m_tready = 0. Required:
  - The beat stays valid until m_tready = 1, then busy falls with no done pulse.
  - Separately, rst_n = 0 mid-packet clears every output to 0 on the next edge.
- Start-ignore: pulse start while busy with different cfg values. Required: no change to the current run; start and abort together in IDLE begins a run.
